pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage RV32 pipeline. Each cycle it produces the enable and flush strobes for the PC and the four pipeline buffer registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use hazards, taken-branch/jump redirects, data-memory wait states and the `halt` drain sequence, and counts stall cycles. It sits beside the datapath, reading decode, ID/EX and EX/MEM fields and driving only control strobes.

## Interface
- `DRAIN_CYCLES`, 2: cycles from leaving RUN (halt seen in EX) until HALTED is entered.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in IF/ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  the IF/ID instruction reads rs1 / rs2.
- `ex_memread`  in  1  ID/EX MemRead.
- `ex_rd`  in  5  ID/EX rd.
- `ex_halt`  in  1  ID/EX halt.
- `ex_redirect`  in  1  EX resolved a taken branch, JAL or JALR.
- `mem_req`  in  1  EX/MEM MemRead | MemWrite.
- `dmem_ready`  in  1  data memory has completed the MEM-stage access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  register load enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush`  out  1 each  load a bubble (all control bits 0) instead of the upstream value.
- `halted`  out  1  pipeline fully drained after halt.
- `stall_cnt`  out  CNT_W  saturating count of stall cycles.

## Operation
- States: RUN, DRAIN, HALTED. Registered state, drain counter `dcnt` and `stall_cnt`. All other outputs are combinational from state and inputs.
- Defaults (RUN, no event): all `*_en`=1, all flushes=0.
- Event priority, highest first: MEMWAIT > HALT > REDIRECT > LOADUSE.
- MEMWAIT (`mem_req & !dmem_ready`, in any state except HALTED):
  - `pc_en`=`if_id_en`=`id_ex_en`=`ex_mem_en`=0.
  - `mem_wb_en`=1 with `mem_wb_flush`=1.
  - Lower-priority events are ignored. They re-present next cycle because EX is frozen.
- HALT (RUN, `ex_halt`):
  - `pc_en`=0, `if_id_flush`=1, `id_ex_flush`=1.
  - Next state DRAIN, `dcnt`←DRAIN_CYCLES.
  - HALT wins if `ex_redirect` is also set.
- REDIRECT (RUN, `ex_redirect`): `pc_en`=1 (PC takes the target), `if_id_flush`=1, `id_ex_flush`=1. Any coincident load-use is on the wrong path and is discarded.
- LOADUSE (RUN):
  - Condition: `ex_memread & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))`.
  - `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1.
- DRAIN:
  - `pc_en`=0, `if_id_flush`=1, `id_ex_flush`=1.
  - `ex_mem_en`=`mem_wb_en`=1 so the halt instruction retires.
  - `ex_halt`, `ex_redirect` and load-use are ignored.
  - In each cycle without MEMWAIT: if `dcnt`==1 go to HALTED, else decrement `dcnt`.
  - During MEMWAIT, `dcnt` holds.
- HALTED:
  - All `*_en`=0, all flushes=0, `halted`=1.
  - All inputs are ignored. Exit only via reset.
- A flush takes precedence over its matching enable: when a flush is 1, the register loads a bubble regardless of the enable.
- `stall_cnt` increments by 1 on each RUN or DRAIN cycle with MEMWAIT or LOADUSE active, and saturates at 2^CNT_W−1.

## Timing
- Reset (`rst_n`=0, asynchronous): state=RUN, `dcnt`=0, `stall_cnt`=0, `halted`=0. While `rst_n`=0, all `*_en`=0 and all flushes=0.
- Release: the first rising edge with `rst_n`=1 operates as RUN.
- Load-use costs exactly 1 cycle. The next cycle has a bubble in ID/EX, so `ex_memread`=0.
- Redirect costs 2 bubbles (IF/ID and ID/EX), with no extra cycle.
- Halt seen in EX in cycle t: DRAIN during t+1 and t+2, and `halted`=1 from cycle t+3. Each MEMWAIT cycle during drain adds one cycle.
- MEMWAIT lasts exactly as long as `dmem_ready`=0. The freeze releases in the same cycle `dmem_ready` rises.
- Reset asserted mid-DRAIN, mid-MEMWAIT or in HALTED returns to RUN immediately.

## Test plan
- Load-use: `lw x5` in EX, `add x6,x5,x1` in ID → one cycle with `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1, then defaults. `stall_cnt`=1.
- x0 and no-use cases: `ex_rd`=0, or a match only on an unused source → no stall.
- Redirect with coincident load-use → `pc_en`=1, `if_id_flush`=`id_ex_flush`=1, `stall_cnt` unchanged.
- MEMWAIT: `mem_req`=1 with `dmem_ready`=0 for 3 cycles, during a pending redirect → 3 freeze cycles with `mem_wb_flush`=1. Then the redirect is honoured on the 4th cycle. `stall_cnt`=3.
- Halt: `ex_halt` at t → `halted`=1 at t+3. With 2 MEMWAIT cycles during drain → `halted`=1 at t+5. After that, all enables stay 0 for 20 cycles.
- Async reset: assert `rst_n`=0 mid-edge in HALTED → state RUN, `halted`=0 and `stall_cnt`=0 immediately, without waiting for a clock edge.
- Saturation: with `CNT_W`=4, 20 load-use cycles → `stall_cnt`=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Purpose:
//   Bundles the hazard-detection inputs that the datapath presents to the
//   stall/flush sequencer and the strobes the sequencer returns.
//
// Modports:
//   master : datapath side. Drives the decode/EX/MEM fields and dmem_ready.
//            Receives the enables, flushes, halted and stall_cnt.
//   slave  : sequencer side (pipe_hazard_ctrl). Mirror of master.
//
// Signals:
//   id_rs1, id_rs2            source registers of the IF/ID instruction
//   id_uses_rs1, id_uses_rs2  IF/ID instruction actually reads rs1 / rs2
//   ex_memread, ex_rd         ID/EX MemRead and destination register
//   ex_halt                   ID/EX holds a halt instruction
//   ex_redirect               EX resolved a taken branch / JAL / JALR
//   mem_req                   EX/MEM performs a data-memory access
//   dmem_ready                data memory completed the MEM access this cycle
//   *_en                      pipeline register load enables
//   *_flush                   load a bubble instead of the upstream value
//   halted                    pipeline fully drained after halt
//   stall_cnt                 saturating count of stall cycles
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   // Datapath -> sequencer
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic             ex_memread;
   logic [4:0]       ex_rd;
   logic             ex_halt;
   logic             ex_redirect;
   logic             mem_req;
   logic             dmem_ready;

   // Sequencer -> datapath
   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             mem_wb_flush;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             ex_memread, ex_rd, ex_halt, ex_redirect,
             mem_req, dmem_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, mem_wb_flush,
             halted, stall_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             ex_memread, ex_rd, ex_halt, ex_redirect,
             mem_req, dmem_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, mem_wb_flush,
             halted, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//   Central stall/flush sequencer for the five-stage RV32 pipeline. Every
//   cycle it produces the enables and flush strobes for the PC and the
//   IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles:
//     - data-memory wait states (MEMWAIT)
//     - the halt drain sequence (HALT)
//     - taken branch / jump redirects (REDIRECT)
//     - load-use hazards (LOADUSE)
//   Priority, highest first: MEMWAIT > HALT > REDIRECT > LOADUSE.
//   It also keeps a saturating count of stall cycles.
//
// Parameters:
//   DRAIN_CYCLES  cycles spent in DRAIN before HALTED (must be >= 1)
//   CNT_W         stall counter width (must equal the interface CNT_W)
//
// Ports:
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset
//   hz     pipe_hazard_ctrl_if.slave, hazard inputs and control strobes
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   pipe_hazard_ctrl_if.slave   hz
);

   localparam int DCNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   localparam logic [DCNT_W-1:0] DCNT_INIT = DCNT_W'(DRAIN_CYCLES);
   localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DCNT_W-1:0] dcnt_q,  dcnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic mem_wait;
   logic stall_inc;

   // Un-gated strobes. They are masked by rst_n on their way out.
   logic pc_en_c;
   logic if_id_en_c;
   logic id_ex_en_c;
   logic ex_mem_en_c;
   logic mem_wb_en_c;
   logic if_id_flush_c;
   logic id_ex_flush_c;
   logic mem_wb_flush_c;
   logic halted_c;

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   // x0 is hard-wired to zero, so a load into x0 never creates a dependency.
   // A source field that the instruction does not read (e.g. rs2 of an I-type)
   // must not create a dependency either.
   assign load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                     ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                      (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

   // Once HALTED, memory handshakes are irrelevant: nothing is in flight.
   assign mem_wait = hz.mem_req && !hz.dmem_ready && (state_q != ST_HALTED);

   // ---------------------------------------------------------------------------
   // Next-state and strobe logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here gets a default at the top of the block.
   // A path that skips an assignment would otherwise infer a latch.
   always_comb begin
      state_d        = state_q;
      dcnt_d         = dcnt_q;
      stall_inc      = 1'b0;
      pc_en_c        = 1'b1;
      if_id_en_c     = 1'b1;
      id_ex_en_c     = 1'b1;
      ex_mem_en_c    = 1'b1;
      mem_wb_en_c    = 1'b1;
      if_id_flush_c  = 1'b0;
      id_ex_flush_c  = 1'b0;
      mem_wb_flush_c = 1'b0;
      halted_c       = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            if (mem_wait) begin
               // Freeze everything up to EX/MEM. Let a bubble fall into MEM/WB
               // so the stalled access is not retired twice. Lower-priority
               // events return next cycle, because EX is frozen.
               pc_en_c        = 1'b0;
               if_id_en_c     = 1'b0;
               id_ex_en_c     = 1'b0;
               ex_mem_en_c    = 1'b0;
               mem_wb_flush_c = 1'b1;
               stall_inc      = 1'b1;
            end else if (hz.ex_halt) begin
               // Stop fetching and squash the younger instructions. The halt
               // itself moves on into EX/MEM and retires during DRAIN.
               pc_en_c       = 1'b0;
               if_id_flush_c = 1'b1;
               id_ex_flush_c = 1'b1;
               state_d       = ST_DRAIN;
               dcnt_d        = DCNT_INIT;
            end else if (hz.ex_redirect) begin
               // PC loads the branch target. The two younger instructions are
               // on the wrong path, which includes any load-use they carried.
               if_id_flush_c = 1'b1;
               id_ex_flush_c = 1'b1;
            end else if (load_use) begin
               // Hold PC and IF/ID for one cycle and inject a bubble into
               // ID/EX. Next cycle the load sits in MEM and forwarding covers it.
               pc_en_c       = 1'b0;
               if_id_en_c    = 1'b0;
               id_ex_flush_c = 1'b1;
               stall_inc     = 1'b1;
            end
         end

         ST_DRAIN: begin
            if (mem_wait) begin
               // Same freeze as in RUN. The drain countdown holds so the halt
               // still gets its full retirement window.
               pc_en_c        = 1'b0;
               if_id_en_c     = 1'b0;
               id_ex_en_c     = 1'b0;
               ex_mem_en_c    = 1'b0;
               mem_wb_flush_c = 1'b1;
               stall_inc      = 1'b1;
            end else begin
               // Front end stays squashed. EX/MEM and MEM/WB keep advancing
               // so the halt instruction retires. Halt, redirect and
               // load-use are all ignored here.
               pc_en_c       = 1'b0;
               if_id_flush_c = 1'b1;
               id_ex_flush_c = 1'b1;
               if (dcnt_q <= DCNT_ONE) begin
                  state_d = ST_HALTED;
                  dcnt_d  = '0;
               end else begin
                  dcnt_d  = dcnt_q - DCNT_ONE;
               end
            end
         end

         ST_HALTED: begin
            // Dead stop. Only reset leaves this state.
            pc_en_c     = 1'b0;
            if_id_en_c  = 1'b0;
            id_ex_en_c  = 1'b0;
            ex_mem_en_c = 1'b0;
            mem_wb_en_c = 1'b0;
            halted_c    = 1'b1;
         end

         default: begin
            // Unreachable encoding. Recover to RUN and keep the default strobes.
            state_d = ST_RUN;
            dcnt_d  = '0;
         end
      endcase

      if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments, so every register
   // samples the values from before the edge. That is the only ordering-safe
   // form for state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         dcnt_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // NOTE: the strobes are forced low combinationally while rst_n is low.
   // No pipeline register loads during reset, even before the first clock edge.
   assign hz.pc_en        = rst_n & pc_en_c;
   assign hz.if_id_en     = rst_n & if_id_en_c;
   assign hz.id_ex_en     = rst_n & id_ex_en_c;
   assign hz.ex_mem_en    = rst_n & ex_mem_en_c;
   assign hz.mem_wb_en    = rst_n & mem_wb_en_c;
   assign hz.if_id_flush  = rst_n & if_id_flush_c;
   assign hz.id_ex_flush  = rst_n & id_ex_flush_c;
   assign hz.mem_wb_flush = rst_n & mem_wb_flush_c;
   assign hz.halted       = rst_n & halted_c;
   assign hz.stall_cnt    = stall_cnt_q;

endmodule
